// File: rtl/combat_resolver_if.sv
// +----------------------------------------------------------------------------+
// | Module   : combat_resolver_if                                              |
// | Brief    : Player flags/boxes in, health/death/hit/state out               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

interface combat_resolver_if;
    logic       startscreen;
    logic       punch_flag1, kick_flag1, block_flag1;
    logic       punch_flag2, kick_flag2, block_flag2;
    logic [9:0] RectX, RectY, RectL, RectR, RectU, RectD;
    logic [9:0] Rect2X, Rect2Y, Rect2L, Rect2R, Rect2U, Rect2D;
    logic [6:0] health1, health2;
    logic       deathL, deathR;
    logic       hit1, hit2;
    logic [1:0] atk_state1, atk_state2;

    modport master (
        output startscreen,
        output punch_flag1, kick_flag1, block_flag1,
        output punch_flag2, kick_flag2, block_flag2,
        output RectX, RectY, RectL, RectR, RectU, RectD,
        output Rect2X, Rect2Y, Rect2L, Rect2R, Rect2U, Rect2D,
        input  health1, health2, deathL, deathR, hit1, hit2,
        input  atk_state1, atk_state2
    );

    modport slave (
        input  startscreen,
        input  punch_flag1, kick_flag1, block_flag1,
        input  punch_flag2, kick_flag2, block_flag2,
        input  RectX, RectY, RectL, RectR, RectU, RectD,
        input  Rect2X, Rect2Y, Rect2L, Rect2R, Rect2U, Rect2D,
        output health1, health2, deathL, deathR, hit1, hit2,
        output atk_state1, atk_state2
    );
endinterface

`default_nettype wire

// File: rtl/combat_resolver.sv
// +----------------------------------------------------------------------------+
// | Module   : combat_resolver                                                 |
// | Brief    : Per-player attack FSMs, hit detection, health and KO tracking   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module combat_resolver #(
    parameter int MAX_HEALTH     = 100,
    parameter int PUNCH_DMG      = 5,
    parameter int KICK_DMG       = 8,
    parameter int PUNCH_REACH    = 20,
    parameter int KICK_REACH     = 30,
    parameter int WINDUP_FRAMES  = 4,
    parameter int RECOVER_FRAMES = 12
) (
    input wire logic          frame_clk,
    input wire logic          Reset,
    combat_resolver_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WINDUP  = 2'd1,
        ACTIVE  = 2'd2,
        RECOVER = 2'd3
    } atk_state_t;

    localparam int c_CNT_MAX = (RECOVER_FRAMES > WINDUP_FRAMES) ? RECOVER_FRAMES : WINDUP_FRAMES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    function automatic logic signed [10:0] sext(input logic [9:0] v);
        return {v[9], v};
    endfunction

    function automatic logic [6:0] sat_sub(input logic [6:0] h, input logic [6:0] d);
        return (h > d) ? h - d : 7'd0;
    endfunction

    logic [1:0] w_punch, w_kick, w_block;
    logic [1:0] r_punch_q, r_kick_q;
    logic [6:0] r_health1, r_health2;
    logic       r_deathL, r_deathR, w_dead;
    logic [1:0] w_state [2];
    logic       w_hit   [2];
    logic [6:0] w_dmg   [2];

    assign w_punch = {bus.punch_flag2, bus.punch_flag1};
    assign w_kick  = {bus.kick_flag2,  bus.kick_flag1};
    assign w_block = {bus.block_flag2, bus.block_flag1};
    assign w_dead  = r_deathL | r_deathR;

    // Edge history keeps tracking during startscreen so held flags never fire on exit.
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            r_punch_q <= 2'b00;
            r_kick_q  <= 2'b00;
        end else begin
            r_punch_q <= w_punch;
            r_kick_q  <= w_kick;
        end
    end

    logic signed [10:0] w_x1, w_y1, w_l1, w_r1, w_u1, w_d1;
    logic signed [10:0] w_x2, w_y2, w_l2, w_r2, w_u2, w_d2;
    logic signed [10:0] w_gap;
    logic               w_overlap;

    assign w_x1 = sext(bus.RectX);   assign w_y1 = sext(bus.RectY);
    assign w_l1 = sext(bus.RectL);   assign w_r1 = sext(bus.RectR);
    assign w_u1 = sext(bus.RectU);   assign w_d1 = sext(bus.RectD);
    assign w_x2 = sext(bus.Rect2X);  assign w_y2 = sext(bus.Rect2Y);
    assign w_l2 = sext(bus.Rect2L);  assign w_r2 = sext(bus.Rect2R);
    assign w_u2 = sext(bus.Rect2U);  assign w_d2 = sext(bus.Rect2D);

    // Box gap is the same from either side, so one test serves both attackers.
    assign w_gap     = (w_x1 <= w_x2) ? (w_x2 - w_l2) - (w_x1 + w_r1)
                                      : (w_x1 - w_l1) - (w_x2 + w_r2);
    assign w_overlap = (w_y1 - w_u1 < w_y2 + w_d2) && (w_y2 - w_u2 < w_y1 + w_d1);

    for (genvar gi = 0; gi < 2; gi++) begin : g_player
        atk_state_t          r_state, w_state_nx;
        logic [c_CNT_W-1:0]  r_cnt, w_cnt_nx;
        logic                r_kick, w_kick_nx;
        logic                w_rise_p, w_rise_k;
        logic signed [10:0]  w_reach;
        logic [6:0]          w_base;

        assign w_rise_p = w_punch[gi] & ~r_punch_q[gi];
        assign w_rise_k = w_kick[gi]  & ~r_kick_q[gi];

        always_ff @(posedge frame_clk or negedge Reset) begin
            if (!Reset) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_kick  <= 1'b0;
            end else if (bus.startscreen) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_kick  <= 1'b0;
            end else begin
                r_state <= w_state_nx;
                r_cnt   <= w_cnt_nx;
                r_kick  <= w_kick_nx;
            end
        end

        always_comb begin
            w_state_nx = r_state;
            w_cnt_nx   = r_cnt;
            w_kick_nx  = r_kick;
            case (r_state)
                IDLE: begin
                    if ((w_rise_p || w_rise_k) && !w_dead) begin
                        w_state_nx = WINDUP;
                        w_cnt_nx   = c_CNT_W'(WINDUP_FRAMES - 1);
                        w_kick_nx  = w_rise_k;
                    end
                end
                WINDUP: begin
                    if (r_cnt == '0) w_state_nx = ACTIVE;
                    else             w_cnt_nx   = r_cnt - 1'b1;
                end
                ACTIVE: begin
                    w_state_nx = RECOVER;
                    w_cnt_nx   = c_CNT_W'(RECOVER_FRAMES - 1);
                end
                RECOVER: begin
                    if (r_cnt == '0) w_state_nx = IDLE;
                    else             w_cnt_nx   = r_cnt - 1'b1;
                end
                default: w_state_nx = IDLE;
            endcase
        end

        assign w_reach     = r_kick ? 11'(KICK_REACH) : 11'(PUNCH_REACH);
        assign w_base      = r_kick ? 7'(KICK_DMG)    : 7'(PUNCH_DMG);
        assign w_state[gi] = r_state;
        assign w_hit[gi]   = (r_state == ACTIVE) && w_overlap && (w_gap <= w_reach);
        assign w_dmg[gi]   = (!w_hit[gi] || w_dead) ? 7'd0
                           : (w_block[1-gi] ? (w_base >> 2) : w_base);
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            r_health1 <= 7'(MAX_HEALTH);
            r_health2 <= 7'(MAX_HEALTH);
            r_deathL  <= 1'b0;
            r_deathR  <= 1'b0;
        end else if (bus.startscreen) begin
            r_health1 <= 7'(MAX_HEALTH);
            r_health2 <= 7'(MAX_HEALTH);
            r_deathL  <= 1'b0;
            r_deathR  <= 1'b0;
        end else begin
            r_health1 <= sat_sub(r_health1, w_dmg[1]);
            r_health2 <= sat_sub(r_health2, w_dmg[0]);
            r_deathL  <= r_deathL | (r_health1 == 7'd0);
            r_deathR  <= r_deathR | (r_health2 == 7'd0);
        end
    end

    assign bus.health1    = r_health1;
    assign bus.health2    = r_health2;
    assign bus.deathL     = r_deathL;
    assign bus.deathR     = r_deathR;
    assign bus.hit1       = w_hit[0];
    assign bus.hit2       = w_hit[1];
    assign bus.atk_state1 = w_state[0];
    assign bus.atk_state2 = w_state[1];

endmodule

`default_nettype wire
